// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of memmap: one whole transaction per registered grant.
// Optional grant watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [31:0]             i_m0_addr,
    input  logic [DATA_WIDTH-1:0]   i_m0_data,
    input  logic                    i_m0_wr_valid,
    output logic                    o_m0_wr_ready,
    input  logic [DATA_WIDTH/8-1:0] i_m0_bwe,
    output logic [DATA_WIDTH-1:0]   o_m0_data,
    output logic                    o_m0_rd_valid,
    input  logic                    i_m0_rd_ready,
    input  logic [31:0]             i_m1_addr,
    input  logic [DATA_WIDTH-1:0]   i_m1_data,
    input  logic                    i_m1_wr_valid,
    output logic                    o_m1_wr_ready,
    input  logic [DATA_WIDTH/8-1:0] i_m1_bwe,
    output logic [DATA_WIDTH-1:0]   o_m1_data,
    output logic                    o_m1_rd_valid,
    input  logic                    i_m1_rd_ready,
    output logic [31:0]             o_s_addr,
    output logic [DATA_WIDTH-1:0]   o_s_data,
    output logic [DATA_WIDTH/8-1:0] o_s_bwe,
    output logic                    o_s_wr_valid,
    input  logic                    i_s_wr_ready,
    input  logic [DATA_WIDTH-1:0]   i_s_data,
    input  logic                    i_s_rd_valid,
    output logic                    o_s_rd_ready,
    output logic [1:0]              o_grant,
    output logic                    o_timeout
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e state_q, state_d;
    logic   last_served_q, last_served_d;

    logic                    owned, own_sel;
    logic [31:0]             sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [DATA_WIDTH/8-1:0] sel_bwe;
    logic                    sel_wr, sel_rd, sel_req, done, timeout_hit;
    logic                    resp_wr_ready, resp_rd_valid;
    logic [DATA_WIDTH-1:0]   resp_data;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    assign owned    = (state_q != StIdle);
    assign own_sel  = (state_q == StOwn1);
    assign sel_addr = own_sel ? i_m1_addr     : i_m0_addr;
    assign sel_data = own_sel ? i_m1_data     : i_m0_data;
    assign sel_bwe  = own_sel ? i_m1_bwe      : i_m0_bwe;
    assign sel_wr   = own_sel ? i_m1_wr_valid : i_m0_wr_valid;
    assign sel_rd   = own_sel ? i_m1_rd_ready : i_m0_rd_ready;
    assign sel_req  = owned & (sel_wr | sel_rd);
    // A pending write masks the read, so only the write handshake can complete.
    assign done     = owned & ((sel_wr & i_s_wr_ready) | (~sel_wr & sel_rd & i_s_rd_valid));

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;

    assign timeout_hit = sel_req & ~done & (wdog_q == 16'(TIMEOUT_CYCLES - 1));
    assign wdog_d      = owned ? wdog_q + 16'd1 : 16'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        o_s_addr      = '0;
        o_s_data      = '0;
        o_s_bwe       = '0;
        o_s_wr_valid  = 1'b0;
        o_s_rd_ready  = 1'b0;
        o_timeout     = 1'b0;
        resp_wr_ready = 1'b0;
        resp_rd_valid = 1'b0;
        resp_data     = '0;
        case (state_q)
            StIdle: begin
                // On a tie the master that was not served last wins.
                if ((i_m0_wr_valid | i_m0_rd_ready) &&
                    (!(i_m1_wr_valid | i_m1_rd_ready) || last_served_q)) begin
                    state_d = StOwn0;
                end else if (i_m1_wr_valid | i_m1_rd_ready) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (timeout_hit) begin
                    o_timeout     = 1'b1;
                    resp_wr_ready = sel_wr;
                    resp_rd_valid = ~sel_wr;
                end else begin
                    o_s_addr      = sel_addr;
                    o_s_data      = sel_data;
                    o_s_bwe       = sel_bwe;
                    o_s_wr_valid  = sel_wr;
                    o_s_rd_ready  = sel_rd & ~sel_wr;
                    resp_wr_ready = sel_wr & i_s_wr_ready;
                    resp_rd_valid = sel_rd & ~sel_wr & i_s_rd_valid;
                    resp_data     = i_s_data;
                end
                if (!sel_req) begin
                    state_d = StIdle;
                end else if (done || timeout_hit) begin
                    state_d       = StIdle;
                    last_served_d = own_sel;
                end
            end
            default: state_d = StIdle;
        endcase
        o_m0_wr_ready = resp_wr_ready & ~own_sel;
        o_m0_rd_valid = resp_rd_valid & ~own_sel;
        o_m0_data     = own_sel ? '0 : resp_data;
        o_m1_wr_ready = resp_wr_ready & own_sel;
        o_m1_rd_valid = resp_rd_valid & own_sel;
        o_m1_data     = own_sel ? resp_data : '0;
    end

    assign o_grant = {state_q == StOwn1, state_q == StOwn0};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run against a
// transaction-level model. Honours BUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8.
module tb_bus_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_bwe [2];
    logic        m_wr [2];
    logic        m_rd [2];
    logic        s_wr_ready, s_rd_valid;
    logic [31:0] s_rdata;

    logic        m0_wr_ready, m0_rd_valid, m1_wr_ready, m1_rd_valid;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_bwe;
    logic        s_wr_valid, s_rd_ready, timeout;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;

    wire [69:0]  obs_s   = {s_addr, s_wdata, s_bwe, s_wr_valid, s_rd_ready};
    wire [33:0]  obs_m0  = {m0_wr_ready, m0_rd_valid, m0_rdata};
    wire [33:0]  obs_m1  = {m1_wr_ready, m1_rd_valid, m1_rdata};
    wire [140:0] all_out = {grant, timeout, obs_s, obs_m0, obs_m1};

    always #5 clk = ~clk;

    bus_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_addr(m_addr[0]), .i_m0_data(m_wdata[0]), .i_m0_wr_valid(m_wr[0]),
        .o_m0_wr_ready(m0_wr_ready), .i_m0_bwe(m_bwe[0]), .o_m0_data(m0_rdata),
        .o_m0_rd_valid(m0_rd_valid), .i_m0_rd_ready(m_rd[0]),
        .i_m1_addr(m_addr[1]), .i_m1_data(m_wdata[1]), .i_m1_wr_valid(m_wr[1]),
        .o_m1_wr_ready(m1_wr_ready), .i_m1_bwe(m_bwe[1]), .o_m1_data(m1_rdata),
        .o_m1_rd_valid(m1_rd_valid), .i_m1_rd_ready(m_rd[1]),
        .o_s_addr(s_addr), .o_s_data(s_wdata), .o_s_bwe(s_bwe), .o_s_wr_valid(s_wr_valid),
        .i_s_wr_ready(s_wr_ready), .i_s_data(s_rdata), .i_s_rd_valid(s_rd_valid),
        .o_s_rd_ready(s_rd_ready), .o_grant(grant), .o_timeout(timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_bwe[i] = '0; m_wr[i] = 1'b0; m_rd[i] = 1'b0;
        end
        s_wr_ready = 1'b0; s_rd_valid = 1'b0; s_rdata = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        m_rd[0] = 1'b1;
        tick(); tick();
        #4;
        n_cmp++;
        if (all_out !== '0) begin
            $display("FAIL reset_outputs got=%h exp=0", all_out); n_err++;
        end
        rst = 1'b0;
        m_rd[0] = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        clear_inputs();
        m_addr[0] = 32'h10; m_rd[0] = 1'b1; s_rdata = 32'hCAFEBABE;
        #4;
        n_cmp++;
        if ({grant, s_rd_ready} !== 3'b000) begin
            $display("FAIL rd_cycle0 got=%b exp=000", {grant, s_rd_ready}); n_err++;
        end
        tick(); #4;
        n_cmp++;
        if ({grant, s_rd_ready, s_addr} !== {2'b01, 1'b1, 32'h10}) begin
            $display("FAIL rd_grant got=%h exp=%h", {grant, s_rd_ready, s_addr},
                     {2'b01, 1'b1, 32'h10}); n_err++;
        end
        tick(); #4;
        n_cmp++;
        if (m0_rd_valid !== 1'b0) begin
            $display("FAIL rd_early_valid got=%b exp=0", m0_rd_valid); n_err++;
        end
        tick();
        s_rd_valid = 1'b1;
        #4;
        n_cmp++;
        if ({obs_m0, obs_m1} !== {1'b0, 1'b1, 32'hCAFEBABE, 34'h0}) begin
            $display("FAIL rd_data got=%h exp=%h", {obs_m0, obs_m1},
                     {1'b0, 1'b1, 32'hCAFEBABE, 34'h0}); n_err++;
        end
        tick();
        clear_inputs();
        #4;
        n_cmp++;
        if (grant !== 2'b00) begin
            $display("FAIL rd_release got=%b exp=00", grant); n_err++;
        end
        tick();
    endtask

    task automatic test_round_robin;
        clear_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            m_addr[0] = 32'hFFFF; m_wdata[0] = 32'h41; m_bwe[0] = 4'hF; m_wr[0] = 1'b1;
            m_addr[1] = 32'h100; m_rd[1] = 1'b1;
            s_wr_ready = 1'b1; s_rd_valid = 1'b1; s_rdata = 32'h5A5A_0000 + rep;
            #4;
            n_cmp++;
            if (grant !== 2'b00) begin
                $display("FAIL rr_idle0 rep=%0d got=%b exp=00", rep, grant); n_err++;
            end
            tick(); #4;
            n_cmp++;
            if ({grant, s_wr_valid, s_addr, s_wdata, m0_wr_ready, m1_rd_valid} !==
                {2'b01, 1'b1, 32'hFFFF, 32'h41, 1'b1, 1'b0}) begin
                $display("FAIL rr_m0_first rep=%0d grant=%b s_addr=%h s_data=%h wr_ready=%b",
                         rep, grant, s_addr, s_wdata, m0_wr_ready); n_err++;
            end
            tick();
            m_wr[0] = 1'b0;
            #4;
            n_cmp++;
            if (grant !== 2'b00) begin
                $display("FAIL rr_gap rep=%0d got=%b exp=00", rep, grant); n_err++;
            end
            tick(); #4;
            n_cmp++;
            if ({grant, s_rd_ready, s_addr, m1_rd_valid, m1_rdata} !==
                {2'b10, 1'b1, 32'h100, 1'b1, 32'h5A5A_0000 + rep}) begin
                $display("FAIL rr_m1_second rep=%0d grant=%b s_addr=%h rd_valid=%b data=%h",
                         rep, grant, s_addr, m1_rd_valid, m1_rdata); n_err++;
            end
            tick();
            clear_inputs();
            tick();
        end
    endtask

    task automatic test_write_wins;
        clear_inputs();
        m_addr[0] = 32'h20; m_wdata[0] = 32'h1234; m_bwe[0] = 4'h3;
        m_wr[0] = 1'b1; m_rd[0] = 1'b1; s_rd_valid = 1'b1;
        tick(); #4;
        n_cmp++;
        if ({s_wr_valid, s_rd_ready, m0_wr_ready, m0_rd_valid} !== 4'b1000) begin
            $display("FAIL ww_write_only got=%b exp=1000",
                     {s_wr_valid, s_rd_ready, m0_wr_ready, m0_rd_valid}); n_err++;
        end
        tick();
        s_wr_ready = 1'b1;
        #4;
        n_cmp++;
        if ({m0_wr_ready, m0_rd_valid, s_rd_ready} !== 3'b100) begin
            $display("FAIL ww_write_done got=%b exp=100",
                     {m0_wr_ready, m0_rd_valid, s_rd_ready}); n_err++;
        end
        tick();
        m_wr[0] = 1'b0; s_wr_ready = 1'b0;
        #4;
        n_cmp++;
        if ({grant, s_rd_ready} !== 3'b000) begin
            $display("FAIL ww_gap got=%b exp=000", {grant, s_rd_ready}); n_err++;
        end
        tick(); #4;
        n_cmp++;
        if ({grant, s_wr_valid, s_rd_ready, m0_rd_valid} !== 5'b01011) begin
            $display("FAIL ww_read_later got=%b exp=01011",
                     {grant, s_wr_valid, s_rd_ready, m0_rd_valid}); n_err++;
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_abort;
        // last served is M0 here, so a tie after the abort must still go to M1
        clear_inputs();
        m_addr[1] = 32'h300; m_rd[1] = 1'b1;
        tick(); #4;
        n_cmp++;
        if ({grant, s_rd_ready} !== 3'b101) begin
            $display("FAIL ab_grant got=%b exp=101", {grant, s_rd_ready}); n_err++;
        end
        tick();
        m_rd[1] = 1'b0;
        #4;
        n_cmp++;
        if ({m1_rd_valid, s_rd_ready} !== 2'b00) begin
            $display("FAIL ab_drop got=%b exp=00", {m1_rd_valid, s_rd_ready}); n_err++;
        end
        tick();
        m_wr[0] = 1'b1; m_rd[1] = 1'b1;
        #4;
        n_cmp++;
        if (grant !== 2'b00) begin
            $display("FAIL ab_idle got=%b exp=00", grant); n_err++;
        end
        tick(); #4;
        n_cmp++;
        if (grant !== 2'b10) begin
            $display("FAIL ab_last_kept got=%b exp=10", grant); n_err++;
        end
        s_rd_valid = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        clear_inputs();
        m_wr[0] = 1'b1; s_wr_ready = 1'b1;
        tick(); tick();
        clear_inputs();
        tick();
        m_addr[1] = 32'h400; m_wr[1] = 1'b1;
        tick(); #4;
        n_cmp++;
        if ({grant, s_wr_valid} !== 3'b101) begin
            $display("FAIL rm_owned got=%b exp=101", {grant, s_wr_valid}); n_err++;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; m_wr[0] = 1'b1;
        #4;
        n_cmp++;
        if (all_out !== '0) begin
            $display("FAIL rm_outputs got=%h exp=0", all_out); n_err++;
        end
        tick(); #4;
        n_cmp++;
        if (grant !== 2'b01) begin
            $display("FAIL rm_tie_m0 got=%b exp=01", grant); n_err++;
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_timeout;
        clear_inputs();
        m_addr[0] = 32'h40; m_rd[0] = 1'b1; s_rdata = 32'hDEADBEEF;
        tick();
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            #4;
            n_cmp++;
            if (k < TO) begin
                if ({grant, timeout} !== 3'b010) begin
                    $display("FAIL to_wait k=%0d got=%b exp=010", k, {grant, timeout}); n_err++;
                end
            end else if ({timeout, m0_rd_valid, m0_rdata, s_rd_ready} !== {2'b11, 32'h0, 1'b0}) begin
                $display("FAIL to_fire timeout=%b rd_valid=%b data=%h s_rd_ready=%b",
                         timeout, m0_rd_valid, m0_rdata, s_rd_ready); n_err++;
            end
            tick();
        end
        #4;
        n_cmp++;
        if ({grant, timeout} !== 3'b000) begin
            $display("FAIL to_idle got=%b exp=000", {grant, timeout}); n_err++;
        end
`else
        for (int k = 1; k <= TO + 4; k++) begin
            #4;
            n_cmp++;
            if ({grant, timeout} !== 3'b010) begin
                $display("FAIL to_held k=%0d got=%b exp=010", k, {grant, timeout}); n_err++;
            end
            tick();
        end
`endif
        clear_inputs();
        tick(); tick();
    endtask

    // Transaction-level model: who owns the bus, who was served last, how long it has been held.
    task automatic test_random;
        int owner, last, held, n;
        logic wr, rd, fin, to_now, stall;
        logic [1:0]  e_grant;
        logic        e_to;
        logic [69:0] e_s;
        logic [33:0] e_m [2];
        clear_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        owner = -1; last = 1; held = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(99) == 0);
            stall = (((cyc / 64) % 4) == 3);
            for (int i = 0; i < 2; i++) begin
                int kind;
                logic on;
                on = (owner == i) ? ($urandom_range(31) != 0) : ($urandom_range(1) == 1);
                kind = $urandom_range(2);
                m_wr[i]    = on && kind != 1;
                m_rd[i]    = on && kind != 0;
                m_addr[i]  = $urandom;
                m_wdata[i] = $urandom;
                m_bwe[i]   = 4'($urandom_range(15));
            end
            s_wr_ready = !stall && ($urandom_range(2) == 0);
            s_rd_valid = !stall && ($urandom_range(2) == 0);
            s_rdata    = $urandom;
            #4;
            e_grant = 2'b00; e_to = 1'b0; e_s = '0; e_m[0] = '0; e_m[1] = '0;
            fin = 1'b0; to_now = 1'b0; wr = 1'b0; rd = 1'b0;
            if (owner >= 0) begin
                n = owner;
                wr = m_wr[n]; rd = m_rd[n];
                e_grant = (n == 0) ? 2'b01 : 2'b10;
                fin = wr ? s_wr_ready : (rd & s_rd_valid);
`ifdef BUS_ARB_TIMEOUT_EN
                to_now = (wr | rd) && !fin && (held == TO - 1);
`endif
                if (to_now) begin
                    e_to = 1'b1;
                    e_m[n] = {wr, !wr, 32'h0};
                end else begin
                    e_s = {m_addr[n], m_wdata[n], m_bwe[n], wr, rd & !wr};
                    e_m[n] = {wr & s_wr_ready, rd & !wr & s_rd_valid, s_rdata};
                end
            end
            n_cmp++;
            if ({grant, timeout} !== {e_grant, e_to}) begin
                $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, {grant, timeout},
                         {e_grant, e_to}); n_err++;
            end
            n_cmp++;
            if (obs_s !== e_s) begin
                $display("FAIL rnd_slave cyc=%0d got=%h exp=%h", cyc, obs_s, e_s); n_err++;
            end
            n_cmp++;
            if ({obs_m0, obs_m1} !== {e_m[0], e_m[1]}) begin
                $display("FAIL rnd_masters cyc=%0d got=%h exp=%h", cyc, {obs_m0, obs_m1},
                         {e_m[0], e_m[1]}); n_err++;
            end
            if (rst) begin
                owner = -1; last = 1; held = 0;
            end else if (owner < 0) begin
                held = 0;
                if ((m_wr[0] | m_rd[0]) && (m_wr[1] | m_rd[1])) owner = 1 - last;
                else if (m_wr[0] | m_rd[0]) owner = 0;
                else if (m_wr[1] | m_rd[1]) owner = 1;
            end else if (!(wr | rd)) begin
                owner = -1;
            end else if (fin || to_now) begin
                last = owner; owner = -1;
            end else begin
                held++;
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wins();
        test_abort();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
